chime_sequencer: RTL and testbench
==================================

# chime_sequencer

Source-side controller for the doorbell chime path. Debounces the push-button, then plays a two-note "ding-dong": it generates the two square-wave tones and the note-select signal that the downstream two-input tone multiplexer consumes as its `a`, `b` and `sel` inputs. The block then holds off for a rest period before it accepts another press.

## Interface
Parameters:
- `DIV_A`, default 4: half-period of tone A, in clocks; minimum 1.
- `DIV_B`, default 6: half-period of tone B, in clocks; minimum 1.
- `NOTE_LEN`, default 48: duration of each note and of the rest, in clocks; minimum 2.
- `DEBOUNCE`, default 8: consecutive stable cycles required for a level change; minimum 1.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `button`, in, 1: raw asynchronous push-button, active-high.
- `a`, out, 1: tone A square wave; 0 outside the DING state.
- `b`, out, 1: tone B square wave; 0 outside the DONG state.
- `sel`, out, 1: 1 in DONG, 0 otherwise; drives the mux select.
- `busy`, out, 1: 1 in any state other than IDLE.

## Operation
- **Synchroniser.** `button` passes through two flops to produce `btn_s`.
- **Debounce.** `btn_db` holds the accepted button level.
  - When `btn_s != btn_db`, the counter increments.
  - When the counter is at `DEBOUNCE-1` and the levels still differ, `btn_db` flips and the counter clears.
  - The counter clears on any cycle where `btn_s == btn_db`.
  - Counter width is `$clog2(DEBOUNCE+1)`.
- **Press detection.** A press is the registered 0→1 transition of `btn_db`, a one-cycle pulse. A held button produces exactly one press. The button must release (debounced) before another press can occur.
- **FSM states:** IDLE, DING, DONG, REST.
  - IDLE → DING on a press.
  - DING → DONG when the note counter reaches `NOTE_LEN-1`.
  - DONG → REST when the note counter reaches `NOTE_LEN-1`.
  - REST → IDLE when the note counter reaches `NOTE_LEN-1`.
- **Note counter.** Clears on every state entry. Width is `$clog2(NOTE_LEN)`.
- **Tone generation.**
  - On entry to DING or DONG, the tone divider and the active tone output clear to 0.
  - The tone toggles when the divider reaches `DIV-1`, and the divider wraps to 0.
  - The resulting period is `2*DIV` clocks.
  - All outputs are registered.
- **Presses outside IDLE.** A press in REST is always ignored. Handling in DING and DONG depends on the Configuration section.
- **Reset values.** Reset clears everything to 0: synchroniser, `btn_db`, counters, `a`, `b`, `sel`, `busy`, and state (IDLE). If the button is held through reset release, it yields a fresh press after the debounce delay.

## Timing
- **Press latency.** Let `button` be high and stable before edge 1. Then:
  - `btn_s` is high after edge 2.
  - `btn_db` is high after edge `2+DEBOUNCE`.
  - The state is DING, `busy`=1 and `sel`=0 after edge `3+DEBOUNCE`.
- **First toggles.** In DING, `a` first rises after `DIV_A` cycles in state. In DONG, `b` first rises after `DIV_B` cycles in state.
- **Note switch.** `sel` goes to 1 and `a` goes to 0 on the same edge that enters DONG. `b` is 0 on that edge.
- **Full cycle.** The total busy time is exactly `3*NOTE_LEN` cycles.
- **Glitch rejection.** A `btn_s` pulse shorter than `DEBOUNCE` cycles never changes `btn_db`.

## Configuration
- `CHIME_RETRIGGER_EN` defined: a press in DING or DONG restarts DING. The note counter, the divider and `a` clear, `b` and `sel` go to 0, and the next state is DING.
- `CHIME_RETRIGGER_EN` undefined: presses in every non-IDLE state are ignored.

## Test plan
Default parameters apply.
- **Reset.** Assert `rst_n`=0 mid-DONG → asynchronously `a`=`b`=`sel`=`busy`=0. After release, the block is IDLE and stays quiet with `button`=0.
- **Single press.** Hold `button` 1 for 30 cycles →
  - `busy` rises after edge 11;
  - `a` has period 8 for 48 cycles;
  - then `sel`=1 and `b` has period 12 for 48 cycles;
  - then 48 rest cycles, then `busy`=0;
  - exactly one chime.
- **Bounce.** Drive `button` high for 5 cycles, low for 3, repeated ×4 → no press and `busy` stays 0.
- **Press during REST.** A clean press during REST is ignored → `busy` falls 144 cycles after the original DING entry.
- **Retrigger on.** With `CHIME_RETRIGGER_EN` defined, press cleanly (release, then press) so that DING is entered at DONG cycle 20 → `sel` goes 0 and DING restarts for a full 48 cycles. Undefined: the DONG continues unchanged.
- **Held through reset.** Keep `button` held while `rst_n` pulses → after release, a new chime starts 11 cycles later.

Source files
------------

// File: rtl/chime_sequencer.sv
// Doorbell chime source: synchronises and debounces the button, then plays a
// two-note ding-dong (tone A, then tone B with sel=1) followed by a rest.
// Optional CHIME_RETRIGGER_EN: a press while a note is playing restarts DING.
module chime_sequencer #(
  parameter int DIV_A    = 4,
  parameter int DIV_B    = 6,
  parameter int NOTE_LEN = 48,
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic a,
  output logic b,
  output logic sel,
  output logic busy
);

  localparam int DBW     = $clog2(DEBOUNCE + 1);
  localparam int NW      = $clog2(NOTE_LEN);
  localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int DW      = $clog2(DIV_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE - 1);
  localparam logic [NW-1:0]  NOTE_LAST = NW'(NOTE_LEN - 1);
  localparam logic [DW-1:0]  A_LAST    = DW'(DIV_A - 1);
  localparam logic [DW-1:0]  B_LAST    = DW'(DIV_B - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DING = 2'd1,
    DONG = 2'd2,
    REST = 2'd3
  } state_t;

  state_t         state;
  logic [1:0]     sync_q;
  logic           btn_s;
  logic           btn_db;
  logic           db_q;
  logic [DBW-1:0] db_cnt;
  logic [NW-1:0]  note_cnt;
  logic [DW-1:0]  div_cnt;
  logic           press;
  logic           retrig;
  logic           note_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], button};
    end
  end

  assign btn_s = sync_q[1];

  // btn_db only follows btn_s after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
      db_q   <= 1'b0;
    end else begin
      db_q <= btn_db;
      if (btn_s != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press     = btn_db & ~db_q;
  assign note_last = (note_cnt == NOTE_LAST);

`ifdef CHIME_RETRIGGER_EN
  assign retrig = press && ((state == DING) || (state == DONG));
`else
  assign retrig = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      note_cnt <= '0;
      div_cnt  <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      sel      <= 1'b0;
      busy     <= 1'b0;
    end else if (retrig) begin
      state    <= DING;
      note_cnt <= '0;
      div_cnt  <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      sel      <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state    <= DING;
            note_cnt <= '0;
            div_cnt  <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        DING: begin
          if (note_last) begin
            state    <= DONG;
            note_cnt <= '0;
            div_cnt  <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            sel      <= 1'b1;
          end else begin
            note_cnt <= note_cnt + 1'b1;
            if (div_cnt == A_LAST) begin
              a       <= ~a;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        DONG: begin
          if (note_last) begin
            state    <= REST;
            note_cnt <= '0;
            div_cnt  <= '0;
            b        <= 1'b0;
            sel      <= 1'b0;
          end else begin
            note_cnt <= note_cnt + 1'b1;
            if (div_cnt == B_LAST) begin
              b       <= ~b;
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        REST: begin
          // Presses here are dropped: the rest period always runs to completion.
          if (note_last) begin
            state    <= IDLE;
            note_cnt <= '0;
            busy     <= 1'b0;
          end else begin
            note_cnt <= note_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer: directed scenarios plus random
// button activity, checked every cycle against a timeline model of the chime.
module tb_chime_sequencer;

  localparam int DIV_A    = 4;
  localparam int DIV_B    = 6;
  localparam int NOTE_LEN = 48;
  localparam int DEBOUNCE = 8;
  localparam int N        = NOTE_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic a, b, sel, busy;

  chime_sequencer #(
    .DIV_A(DIV_A), .DIV_B(DIV_B), .NOTE_LEN(NOTE_LEN), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .a(a), .b(b), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raw samples, accepted level history, and the start edge of the chime.
  bit samp_q[$];
  bit m_db_n1, m_db_n2;
  int m_run;
  bit m_active;
  int m_start;
  int edge_n = 0;
  int rises = 0;
  int fall_edge = -1;
  bit busy_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp_q   = '{1'b0, 1'b0};
    m_db_n1  = 1'b0;
    m_db_n2  = 1'b0;
    m_run    = 0;
    m_active = 1'b0;
    m_start  = 0;
  endtask

  // Outputs as a pure function of cycles elapsed since the chime began.
  function automatic logic [3:0] expect_out();
    int  k;
    logic ea, eb, es, ey;
    if (!m_active) return 4'b0;
    k = edge_n - m_start;
    if (k < 0 || k >= 3 * N) return 4'b0;
    ey = 1'b1;
    es = (k >= N) && (k < 2 * N);
    ea = (k < N) ? ((k / DIV_A) % 2 == 1) : 1'b0;
    eb = es ? (((k - N) / DIV_B) % 2 == 1) : 1'b0;
    return {ea, eb, es, ey};
  endfunction

  task automatic model_edge();
    bit s_in, pressed, new_db, idle;
    int kp;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // The synchronised level seen by this edge is the button sampled two edges ago.
    s_in = samp_q[1];
    samp_q.push_front(button);
    void'(samp_q.pop_back());
    pressed = m_db_n1 & ~m_db_n2;
    new_db  = m_db_n1;
    if (s_in != m_db_n1) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        new_db = ~m_db_n1;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
    m_db_n2 = m_db_n1;
    m_db_n1 = new_db;
    if (pressed) begin
      kp   = edge_n - 1 - m_start;
      idle = !m_active || (kp >= 3 * N);
      if (idle) begin
        m_active = 1'b1;
        m_start  = edge_n;
      end
`ifdef CHIME_RETRIGGER_EN
      else if (kp < 2 * N) begin
        m_start = edge_n;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check("outputs", {28'b0, a, b, sel, busy}, {28'b0, expect_out()});
    if (busy && !busy_prev) rises++;
    if (!busy && busy_prev) fall_edge = edge_n;
    busy_prev = busy;
  endtask

  task automatic drive(input logic lvl, input int n);
    button = lvl;
    repeat (n) tick();
  endtask

  task automatic run_until(input int target);
    while (edge_n < target) tick();
  endtask

  initial begin
    int st;
    int wait_n;
    int exp_fall;
    model_reset();

    // Reset and quiet idle
    rst_n = 1'b0;
    drive(1'b0, 3);
    check("reset_state", {28'b0, a, b, sel, busy}, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 20);

    // Single press, held 30 cycles: exactly one chime
    rises = 0;
    drive(1'b1, 30);
    st = m_start;
    check("single_start_edge", st, edge_n - 30 + 11);
    drive(1'b0, 3 * N + 20);
    check("single_chime_count", rises, 1);
    check("single_busy_len", fall_edge - st, 3 * N);

    // Bounce: 5 high / 3 low repeated four times
    rises = 0;
    repeat (4) begin
      drive(1'b1, 5);
      drive(1'b0, 3);
    end
    drive(1'b0, 20);
    check("bounce_no_press", rises, 0);

    // Clean press landing in REST is ignored
    drive(1'b1, 15);
    st = m_start;
    drive(1'b0, 1);
    run_until(st + 2 * N + 5 - 11);
    drive(1'b1, 15);
    button = 1'b0;
    run_until(st + 3 * N + 40);
    check("rest_press_fall", fall_edge, st + 3 * N);

    // Second press timed to land at DONG cycle 20
    drive(1'b1, 15);
    st = m_start;
    drive(1'b0, 1);
    run_until(st + N + 20 - 11);
    drive(1'b1, 15);
    button = 1'b0;
    run_until(st + N + 20 + 3 * N + 30);
`ifdef CHIME_RETRIGGER_EN
    exp_fall = st + N + 20 + 3 * N;
`else
    exp_fall = st + 3 * N;
`endif
    check("retrig_fall", fall_edge, exp_fall);

    // Asynchronous reset mid-DONG
    drive(1'b1, 15);
    st = m_start;
    drive(1'b0, 1);
    run_until(st + N + 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {28'b0, a, b, sel, busy}, 32'h0);
    model_reset();
    busy_prev = 1'b0;
    drive(1'b0, 3);
    rst_n = 1'b1;
    drive(1'b0, 30);

    // Button held through a reset pulse
    drive(1'b1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    busy_prev = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_n = 0;
    while (busy !== 1'b1 && wait_n < 30) begin
      tick();
      wait_n++;
    end
    check("held_reset_latency", wait_n, 11);
    drive(1'b0, 3 * N + 20);

    // Random button activity
    repeat (40) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end
    drive(1'b0, 3 * N + 30);
    check("final_idle", {28'b0, a, b, sel, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
